// File: rtl/operand_bus_arbiter_pkg.sv
// Shared types and constants for the operand bus arbiter.
// The state encoding is fixed so it can be probed directly from the state register.
package operand_bus_arbiter_pkg;
    localparam int WIDTH_DEF = 16;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;
endpackage

// File: rtl/operand_bus_arbiter_mux.sv
// 16-bit 2:1 bus multiplexer feeding the arbiter output register.
module _2x1_16_bit_mux (
    input  logic [15:0] d0,
    input  logic [15:0] d1,
    input  logic        s,
    output logic [15:0] y
);
    assign y = s ? d1 : d0;
endmodule

// File: rtl/operand_bus_arbiter.sv
// Round-robin arbiter for two operand requesters with bounded bursts and a
// single registered valid/ready output slot.
module operand_bus_arbiter
    import operand_bus_arbiter_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt1,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy
);
    // Handshake: out_data is accepted on any edge where out_valid & out_ready.
    // The slot refills in the same cycle it drains, so take = !out_valid | out_ready.

    state_t           state;
    logic             ptr;
    logic [CNT_W-1:0] cnt;

    logic             take;
    logic             cur_req;
    logic             oth_req;
    logic             xfer;
    logic             expire;
    logic [CNT_W-1:0] cnt_inc;
    logic [15:0]      mux_data;

    _2x1_16_bit_mux u_mux (
        .d0 (data0),
        .d1 (data1),
        .s  (sel),
        .y  (mux_data)
    );

    assign gnt0 = (state == OWN0);
    assign gnt1 = (state == OWN1);
    assign sel  = (state == OWN1);
    assign busy = (state != IDLE);

    always_comb begin
        take    = !out_valid || out_ready;
        cur_req = (state == OWN1) ? req1 : req0;
        oth_req = (state == OWN1) ? req0 : req1;
        xfer    = (state != IDLE) && cur_req && take;
        cnt_inc = cnt + 1'b1;
        expire  = xfer && (cnt_inc == CNT_W'(MAX_BURST));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (ptr ? req1 : req0)
                        state <= ptr ? OWN1 : OWN0;
                    else if (ptr ? req0 : req1)
                        state <= ptr ? OWN0 : OWN1;
                end
                OWN0, OWN1: begin
                    if (xfer)
                        cnt <= cnt_inc;
                    // Hand-over: owner withdrew or its burst just expired.
                    if (!cur_req || expire) begin
                        ptr <= (state == OWN0);
                        cnt <= '0;
                        if (oth_req)
                            state <= (state == OWN0) ? OWN1 : OWN0;
                        else if (!cur_req)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (xfer) begin
                out_data  <= mux_data;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_operand_bus_arbiter.sv
// Bench for operand_bus_arbiter: two instances (MAX_BURST 4 and 2) share one
// stimulus stream and are checked every cycle against a behavioural model.
module tb_operand_bus_arbiter;
    logic        clk;
    logic        rst_n;
    logic        req0, req1, out_ready;
    logic [15:0] data0, data1;
    logic [1:0]  g0, g1, sl, ov, bz;
    logic [15:0] od [2];

    int checks = 0;
    int errors = 0;

    // model: owner -1 = none, ptr, count, output slot
    int          mo [2];
    int          mp [2];
    int          mc [2];
    logic        mv [2];
    logic [15:0] md [2];
    int          mb [2] = '{4, 2};

    operand_bus_arbiter #(.WIDTH(16), .MAX_BURST(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .data0(data0), .gnt0(g0[0]),
        .req1(req1), .data1(data1), .gnt1(g1[0]),
        .sel(sl[0]), .out_valid(ov[0]), .out_data(od[0]),
        .out_ready(out_ready), .busy(bz[0])
    );

    operand_bus_arbiter #(.WIDTH(16), .MAX_BURST(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .data0(data0), .gnt0(g0[1]),
        .req1(req1), .data1(data1), .gnt1(g1[1]),
        .sel(sl[1]), .out_valid(ov[1]), .out_data(od[1]),
        .out_ready(out_ready), .busy(bz[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mo[k] = -1; mp[k] = 0; mc[k] = 0; mv[k] = 1'b0; md[k] = 16'h0;
        end
    endtask

    task automatic model_step();
        bit          r [2];
        logic [15:0] d [2];
        bit          t, xf;
        int          x;
        r[0] = req0; r[1] = req1; d[0] = data0; d[1] = data1;
        for (int k = 0; k < 2; k++) begin
            t  = !mv[k] || out_ready;
            xf = 1'b0;
            if (mo[k] < 0) begin
                if (r[mp[k]]) begin mo[k] = mp[k]; mc[k] = 0; end
                else if (r[1 - mp[k]]) begin mo[k] = 1 - mp[k]; mc[k] = 0; end
            end else begin
                x  = mo[k];
                xf = r[x] && t;
                if (xf) begin md[k] = d[x]; mv[k] = 1'b1; mc[k]++; end
                if (!r[x] || (xf && mc[k] == mb[k])) begin
                    mp[k] = 1 - x;
                    if (r[1 - x]) begin mo[k] = 1 - x; mc[k] = 0; end
                    else if (r[x]) mc[k] = 0;
                    else mo[k] = -1;
                end
            end
            if (!xf && mv[k] && out_ready) mv[k] = 1'b0;
        end
    endtask

    task automatic check_outs();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("gnt0[%0d]", k), {15'b0, g0[k]}, {15'b0, mo[k] == 0});
            chk($sformatf("gnt1[%0d]", k), {15'b0, g1[k]}, {15'b0, mo[k] == 1});
            chk($sformatf("sel[%0d]", k), {15'b0, sl[k]}, {15'b0, mo[k] == 1});
            chk($sformatf("busy[%0d]", k), {15'b0, bz[k]}, {15'b0, mo[k] >= 0});
            chk($sformatf("out_valid[%0d]", k), {15'b0, ov[k]}, {15'b0, mv[k]});
            chk($sformatf("out_data[%0d]", k), od[k], md[k]);
        end
    endtask

    // Inputs change just after a falling edge; outputs are compared there too.
    task automatic tick();
        check_outs();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic r0, input logic r1, input logic [15:0] d0,
                         input logic [15:0] d1, input logic rdy);
        req0 = r0; req1 = r1; data0 = d0; data1 = d1; out_ready = rdy;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 16'h0, 16'h0, 1);
        do_reset();

        // single requester, three words
        drive(1, 0, 16'h0000, 16'h0, 1);
        tick();
        chk("gnt0_after_req", {15'b0, g0[0]}, 16'h1);
        drive(1, 0, 16'h1111, 16'h0, 1); tick();
        chk("word_1111", od[0], 16'h1111);
        drive(1, 0, 16'h2222, 16'h0, 1); tick();
        chk("word_2222", od[0], 16'h2222);
        drive(1, 0, 16'h3333, 16'h0, 1); tick();
        chk("word_3333", od[0], 16'h3333);
        drive(0, 0, 16'h0, 16'h0, 1); tick(); tick();
        chk("idle_after_drop", {15'b0, bz[0]}, 16'h0);

        // contention from reset: 4/4/4 on the MAX_BURST=4 instance
        do_reset();
        drive(1, 1, 16'h0, 16'h0, 1); tick();
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("rr_gnt0_%0d", i), {15'b0, g0[0]}, {15'b0, ((i / 4) % 2) == 0});
            drive(1, 1, 16'h0A00 + 16'(i), 16'h0B00 + 16'(i), 1);
            tick();
        end

        // backpressure during an OWN1 burst
        do_reset();
        drive(0, 1, 16'h0, 16'hBEEF, 1); tick(); tick();
        drive(0, 1, 16'h0, 16'h1234, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_data", od[0], 16'hBEEF);
            chk("bp_hold_gnt1", {15'b0, g1[0]}, 16'h1);
        end
        drive(0, 1, 16'h0, 16'h1234, 1); tick();
        chk("bp_next_word", od[0], 16'h1234);

        // requester 1 alone, five words through burst expiries
        do_reset();
        drive(0, 1, 16'h0, 16'h0, 1); tick();
        for (int i = 1; i <= 5; i++) begin
            drive(0, 1, 16'h0, 16'hA000 + 16'(i), 1); tick();
            chk($sformatf("mb2_word_%0d", i), od[1], 16'hA000 + 16'(i));
        end
        drive(0, 0, 16'h0, 16'h0, 1); tick();

        // requester 0 withdraws after one word while requester 1 waits
        do_reset();
        drive(1, 0, 16'h0, 16'h0, 1); tick();
        drive(1, 1, 16'hC0DE, 16'h0, 1); tick();
        drive(0, 1, 16'h0, 16'hD00D, 1); tick();
        chk("handover_gnt1", {15'b0, g1[0]}, 16'h1);
        drive(0, 1, 16'h0, 16'hD00E, 0); tick();

        // asynchronous reset while OWN1 holds a word
        chk("pre_rst_gnt1", {15'b0, g1[0]}, 16'h1);
        chk("pre_rst_valid", {15'b0, ov[0]}, 16'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_gnt1", {15'b0, g1[0]}, 16'h0);
        chk("async_rst_valid", {15'b0, ov[0]}, 16'h0);
        model_reset();
        check_outs();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 16'h0, 16'h0, 1); tick();
        chk("ptr_after_rst", {15'b0, g0[0]}, 16'h1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  16'($urandom), 16'($urandom), $urandom_range(0, 2) != 0);
            tick();
        end
        check_outs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
